// File: rtl/ysyx_22041412_clint_ctrl.sv
// CLINT register-access controller and tick scheduler.
// Owns mtime, mtimecmp and msip, serialises MMIO requests against the
// prescaled mtime increment, and drives registered timer/soft interrupts.
module ysyx_22041412_clint_ctrl #(
   parameter int PRESCALE = 16,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mtime_en,
   input  logic              mtie,
   input  logic              msie,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              irq_timer,
   output logic              irq_soft,
   output logic [31:0]       mtime_lo
);

   localparam logic [15:0]       PS_LAST      = 16'(PRESCALE - 1);
   localparam logic [ADDR_W-1:0] A_MSIP       = ADDR_W'(32'h0000);
   localparam logic [ADDR_W-1:0] A_MTIMECMP_L = ADDR_W'(32'h4000);
   localparam logic [ADDR_W-1:0] A_MTIMECMP_H = ADDR_W'(32'h4004);
   localparam logic [ADDR_W-1:0] A_MTIME_L    = ADDR_W'(32'hBFF8);
   localparam logic [ADDR_W-1:0] A_MTIME_H    = ADDR_W'(32'hBFFC);

   typedef enum logic {IDLE, RESP} state_t;

   state_t      state, state_nxt;
   logic [15:0] ps_cnt;
   logic        tick;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;

   logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
   logic        dec_err;
   logic [31:0] rd_word;
   logic        accept;
   logic        wr;

   assign tick     = mtime_en && (ps_cnt == PS_LAST);
   assign accept   = (state == IDLE) && req_valid;
   assign wr       = accept && req_we && !dec_err;
   assign mtime_lo = mtime[31:0];

   // Address decode and read mux; reads see the pre-increment register values.
   always_comb begin
      sel_msip    = (req_addr == A_MSIP);
      sel_cmp_lo  = (req_addr == A_MTIMECMP_L);
      sel_cmp_hi  = (req_addr == A_MTIMECMP_H);
      sel_time_lo = (req_addr == A_MTIME_L);
      sel_time_hi = (req_addr == A_MTIME_H);
      dec_err     = (req_addr[1:0] != 2'b00) ||
                    !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi);
      rd_word     = 32'h0;
      if (sel_msip)    rd_word = {31'h0, msip};
      if (sel_cmp_lo)  rd_word = mtimecmp[31:0];
      if (sel_cmp_hi)  rd_word = mtimecmp[63:32];
      if (sel_time_lo) rd_word = mtime[31:0];
      if (sel_time_hi) rd_word = mtime[63:32];
   end

   // Request FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Request FSM next state and handshake outputs.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Response capture at acceptance; held stable throughout RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else if (accept) begin
         resp_err   <= dec_err;
         resp_rdata <= (dec_err || req_we) ? 32'h0 : rd_word;
      end
   end

   // Prescaler: advances only while enabled, wraps on the tick cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          ps_cnt <= 16'h0;
      else if (mtime_en) ps_cnt <= tick ? 16'h0 : ps_cnt + 16'h1;
   end

   // mtime: a CPU word write beats the tick and suppresses that cycle's increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                    mtime         <= 64'h0;
      else if (wr && sel_time_lo)  mtime[31:0]   <= req_wdata;
      else if (wr && sel_time_hi)  mtime[63:32]  <= req_wdata;
      else if (tick)               mtime         <= mtime + 64'h1;
   end

   // mtimecmp and msip software-writable registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip     <= 1'b0;
      end else begin
         if (wr && sel_cmp_lo) mtimecmp[31:0]  <= req_wdata;
         if (wr && sel_cmp_hi) mtimecmp[63:32] <= req_wdata;
         if (wr && sel_msip)   msip            <= req_wdata[0];
      end
   end

   // Registered interrupt lines, one cycle behind the register state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_timer <= 1'b0;
         irq_soft  <= 1'b0;
      end else begin
         irq_timer <= (mtime >= mtimecmp) && mtie;
         irq_soft  <= msip && msie;
      end
   end

endmodule

// File: doc/ysyx_22041412_clint_ctrl.md
Name: ysyx_22041412_clint_ctrl

Overview:
Register-access controller and tick scheduler for the core-local interruptor. Owns the 64-bit mtime counter, mtimecmp compare register and msip bit. Serialises CPU load/store requests against the free-running tick increment, and produces the registered timer and software interrupt lines that go to the CSR/trap unit. Sits between the LSU's MMIO path and the trap logic.

Parameters:
PRESCALE, 16, clk cycles per mtime increment; legal range 1..65535.
ADDR_W, 16, request address width (offset within the CLINT window).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
mtime_en  in  1  count enable; when low, the prescaler and mtime hold
mtie  in  1  mie.MTIE from CSR file
msie  in  1  mie.MSIE from CSR file
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte offset
req_wdata  in  32  write data
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  read data (0 on write or error)
resp_err  out  1  access fault
irq_timer  out  1  machine timer interrupt
irq_soft  out  1  machine software interrupt
mtime_lo  out  32  mtime[31:0], for debug/trace

Behaviour:
Register map (word-aligned): 0x0000 msip (bit0, other bits read 0, ignore writes); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0, FSM = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, irq_timer = 0, irq_soft = 0.
FSM, two states:
- IDLE: req_ready = 1. On req_valid, at that edge: perform the write or capture the read data, set resp_err/resp_rdata, go to RESP.
- RESP: req_ready = 0, resp_valid = 1. resp_rdata/resp_err stay stable until resp_ready. On resp_ready, go to IDLE.
- Latency: response visible the cycle after acceptance. Maximum throughput is one request per 2 cycles.
Errors: addr[1:0] != 0 or an unmapped offset -> resp_err = 1, resp_rdata = 0, no state change.
Prescaler: counts 0..PRESCALE-1 only while mtime_en = 1. A tick occurs in the cycle where count == PRESCALE-1 and mtime_en = 1; the count then wraps to 0. With PRESCALE = 1, a tick occurs every enabled cycle.
Tick: mtime <= mtime + 1 as a full 64-bit add. FFFF_FFFF in the low word carries into the high word. The all-ones value wraps to 0.
Collision: a CPU write to either mtime word in the same cycle as a tick wins. The written word takes the wdata value and the other word keeps its old value; the increment for that cycle is dropped. A CPU read in a tick cycle returns the pre-increment value.
Word writes are independent and have no carry between halves; software is responsible for hi/lo ordering.
Interrupts (registered, one cycle after the register state that causes them):
- irq_timer = (mtime >= mtimecmp, 64-bit unsigned) & mtie.
- irq_soft = msip & msie.
- irq_timer stays high until mtimecmp is raised above mtime or mtie drops.
Asynchronous reset mid-transaction: the FSM returns to IDLE, any pending response is discarded, and all registers take their reset values immediately.
req_valid is ignored while in RESP; the requester must hold it until it sees req_ready.

Test Plan:
1. Reset, then read 0xBFF8/0xBFFC/0x4000 -> rdata 0, 0, FFFF_FFFF; irq_timer = 0; resp_valid one cycle after acceptance.
2. PRESCALE=4, mtime_en=1 for 40 cycles -> mtime_lo = 10. Drop mtime_en for 8 cycles -> mtime_lo remains 10.
3. Write mtime lo = FFFF_FFFE, hi = 0, PRESCALE=1 -> after 2 ticks, hi = 1 and lo = 0.
4. mtimecmp = 20, mtie = 1, mtime counting from 0 at PRESCALE=1 -> irq_timer rises the cycle after mtime reaches 20. Write mtimecmp lo = 100 -> irq_timer falls the cycle after the write.
5. Write mtime lo = 5 in a tick cycle -> mtime_lo = 5 (not 6). Then read 0x0002 -> resp_err = 1. Then read 0x1234 -> resp_err = 1, rdata = 0.
6. Hold resp_ready = 0 for 5 cycles -> resp_valid, rdata and err stay stable, req_ready = 0. Assert rst low in RESP -> resp_valid = 0 immediately and req_ready = 1 after release.
